// File: rtl/adder_tree_pkg.sv
// Shared width helpers and saturation limits for the pipelined adder tree.
package adder_tree_pkg;

    function automatic int at_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int at_levels(input int num_input);
        return at_clog2(num_input);
    endfunction

    function automatic int at_out_width(input int data_width, input int num_input, input int acc_bits);
        return data_width + at_clog2(num_input) + acc_bits;
    endfunction

    function automatic longint at_sat_max(input int width);
        return (longint'(1) << (width - 1)) - longint'(1);
    endfunction

    function automatic longint at_sat_min(input int width);
        return -(longint'(1) << (width - 1));
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One register level of the adder tree: pairwise sign-extended adds plus sideband.
module adder_tree_level #(
    parameter int IN_NUM   = 8,
    parameter int IN_WIDTH = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_stall,
    input  logic                                   i_valid,
    input  logic                                   i_acc_en,
    input  logic                                   i_last,
    input  logic [IN_NUM*IN_WIDTH-1:0]             i_data,
    output logic                                   o_valid,
    output logic                                   o_acc_en,
    output logic                                   o_last,
    output logic [(IN_NUM/2)*(IN_WIDTH+1)-1:0]     o_data
);

    localparam int OUT_NUM   = IN_NUM / 2;
    localparam int OUT_WIDTH = IN_WIDTH + 1;

    logic [OUT_NUM*OUT_WIDTH-1:0] w_sum;
    logic                         r_valid;
    logic                         r_acc_en;
    logic                         r_last;
    logic [OUT_NUM*OUT_WIDTH-1:0] r_data;

    genvar k;
    generate
        for (k = 0; k < OUT_NUM; k++) begin : g_pair
            logic [IN_WIDTH-1:0] w_a;
            logic [IN_WIDTH-1:0] w_b;
            assign w_a = i_data[(2*k)*IN_WIDTH +: IN_WIDTH];
            assign w_b = i_data[(2*k+1)*IN_WIDTH +: IN_WIDTH];
            // One bit of growth per level, so the pairwise sum can never overflow.
            assign w_sum[k*OUT_WIDTH +: OUT_WIDTH] = {w_a[IN_WIDTH-1], w_a} + {w_b[IN_WIDTH-1], w_b};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_acc_en <= 1'b0;
            r_last   <= 1'b0;
            r_data   <= '0;
        end else if (!i_stall) begin
            r_valid  <= i_valid;
            r_acc_en <= i_acc_en;
            r_last   <= i_last;
            r_data   <= w_sum;
        end
    end

    assign o_valid  = r_valid;
    assign o_acc_en = r_acc_en;
    assign o_last   = r_last;
    assign o_data   = r_data;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined N-input signed adder tree with multi-beat accumulation and ready/valid output.
// Define ADDER_TREE_SAT_EN to make the accumulate/final add saturate and drive o_sat.
module adder_tree_pipe
    import adder_tree_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INPUT  = 8,
    parameter int ACC_BITS   = 8
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   i_en,
    input  logic [NUM_INPUT-1:0]                                   i_valid,
    input  logic [NUM_INPUT*DATA_WIDTH-1:0]                        i_data_bus,
    input  logic                                                   i_acc_en,
    input  logic                                                   i_last,
    output logic                                                   o_ready,
    output logic                                                   o_valid,
    output logic [at_out_width(DATA_WIDTH, NUM_INPUT, ACC_BITS)-1:0] o_data_bus,
    output logic                                                   o_sat,
    input  logic                                                   i_ready
);

    localparam int LEVELS    = at_levels(NUM_INPUT);
    localparam int TREE_W    = DATA_WIDTH + LEVELS;
    localparam int OUT_WIDTH = at_out_width(DATA_WIDTH, NUM_INPUT, ACC_BITS);

    logic                            w_stall;
    logic                            w_accept;
    logic [NUM_INPUT*DATA_WIDTH-1:0] w_masked;

    assign w_stall  = o_valid & ~i_ready;
    assign o_ready  = ~w_stall;
    assign w_accept = i_en & (|i_valid);

    always_comb begin
        w_masked = '0;
        for (int k = 0; k < NUM_INPUT; k++) begin
            if (i_valid[k]) w_masked[k*DATA_WIDTH +: DATA_WIDTH] = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    genvar g;
    generate
        for (g = 0; g < LEVELS; g++) begin : g_lvl
            logic [(NUM_INPUT>>g)*(DATA_WIDTH+g)-1:0]         w_in;
            logic                                             w_in_valid;
            logic                                             w_in_acc;
            logic                                             w_in_last;
            logic [(NUM_INPUT>>(g+1))*(DATA_WIDTH+g+1)-1:0]   w_out;
            logic                                             w_out_valid;
            logic                                             w_out_acc;
            logic                                             w_out_last;

            if (g == 0) begin : g_src
                assign w_in       = w_masked;
                assign w_in_valid = w_accept;
                assign w_in_acc   = i_acc_en;
                assign w_in_last  = i_last;
            end else begin : g_src
                assign w_in       = g_lvl[g-1].w_out;
                assign w_in_valid = g_lvl[g-1].w_out_valid;
                assign w_in_acc   = g_lvl[g-1].w_out_acc;
                assign w_in_last  = g_lvl[g-1].w_out_last;
            end

            adder_tree_level #(
                .IN_NUM   (NUM_INPUT >> g),
                .IN_WIDTH (DATA_WIDTH + g)
            ) u_level (
                .clk      (clk),
                .rst      (rst),
                .i_stall  (w_stall),
                .i_valid  (w_in_valid),
                .i_acc_en (w_in_acc),
                .i_last   (w_in_last),
                .i_data   (w_in),
                .o_valid  (w_out_valid),
                .o_acc_en (w_out_acc),
                .o_last   (w_out_last),
                .o_data   (w_out)
            );
        end
    endgenerate

    logic                 w_tv;
    logic                 w_tacc;
    logic                 w_tlast;
    logic [TREE_W-1:0]    w_tree_sum;
    logic [OUT_WIDTH-1:0] w_s_ext;
    logic [OUT_WIDTH-1:0] w_sum;
    logic [OUT_WIDTH-1:0] r_acc;
    logic [OUT_WIDTH-1:0] r_data;
    logic                 r_valid;

    assign w_tv       = g_lvl[LEVELS-1].w_out_valid;
    assign w_tacc     = g_lvl[LEVELS-1].w_out_acc;
    assign w_tlast    = g_lvl[LEVELS-1].w_out_last;
    assign w_tree_sum = g_lvl[LEVELS-1].w_out;
    assign w_s_ext    = OUT_WIDTH'(signed'(w_tree_sum));

`ifdef ADDER_TREE_SAT_EN
    localparam logic [OUT_WIDTH-1:0] SAT_MAX = OUT_WIDTH'(at_sat_max(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0] SAT_MIN = OUT_WIDTH'(at_sat_min(OUT_WIDTH));

    logic [OUT_WIDTH:0] w_wide;
    logic               w_clamp;
    logic               r_sat;
    logic               r_sticky;

    // Overflow shows up as the two top bits of the one-bit-wider sum disagreeing.
    assign w_wide  = {r_acc[OUT_WIDTH-1], r_acc} + {w_s_ext[OUT_WIDTH-1], w_s_ext};
    assign w_clamp = w_wide[OUT_WIDTH] ^ w_wide[OUT_WIDTH-1];
    assign w_sum   = !w_clamp ? w_wide[OUT_WIDTH-1:0] : (w_wide[OUT_WIDTH] ? SAT_MIN : SAT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat    <= 1'b0;
            r_sticky <= 1'b0;
        end else if (!w_stall) begin
            r_sat <= 1'b0;
            if (w_tv && w_tacc) begin
                if (!w_tlast) begin
                    r_sticky <= r_sticky | w_clamp;
                end else begin
                    r_sat    <= r_sticky | w_clamp;
                    r_sticky <= 1'b0;
                end
            end
        end
    end

    assign o_sat = r_sat;
`else
    assign w_sum = r_acc + w_s_ext;
    assign o_sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_acc   <= '0;
        end else if (!w_stall) begin
            // Output register reads as zero whenever it holds no result.
            r_valid <= 1'b0;
            r_data  <= '0;
            if (w_tv) begin
                if (!w_tacc) begin
                    r_valid <= 1'b1;
                    r_data  <= w_s_ext;
                end else if (!w_tlast) begin
                    r_acc <= w_sum;
                end else begin
                    r_valid <= 1'b1;
                    r_data  <= w_sum;
                    r_acc   <= '0;
                end
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_data_bus = r_data;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe: directed cases plus random traffic vs a queue model.
module tb_adder_tree_pipe;

    localparam int DW = 16;
    localparam int N  = 8;
    localparam int AB = 8;
    localparam int LV = 3;
    localparam int OW = DW + LV + AB;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_en;
    logic [N-1:0]      i_valid;
    logic [N*DW-1:0]   i_data_bus;
    logic              i_acc_en;
    logic              i_last;
    logic              o_ready;
    logic              o_valid;
    logic [OW-1:0]     o_data_bus;
    logic              o_sat;
    logic              i_ready;

    always #5 clk = ~clk;

    adder_tree_pipe #(.DATA_WIDTH(DW), .NUM_INPUT(N), .ACC_BITS(AB)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .i_acc_en   (i_acc_en),
        .i_last     (i_last),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .o_sat      (o_sat),
        .i_ready    (i_ready)
    );

    typedef struct { longint d; bit s; } exp_t;
    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     delivered = 0;
    longint last_out;
    bit     last_sat;
    bit     obs_valid;
    bit     last_acc;
    bit     saw_stall;
    longint m_acc = 0;
    bit     m_sticky = 0;

    localparam longint MAXV = (longint'(1) << (OW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (OW - 1));

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrapv(input longint v);
        longint m;
        m = v & ((longint'(1) << OW) - 1);
        if (m >= (longint'(1) << (OW - 1))) m = m - (longint'(1) << OW);
        return m;
    endfunction

    function automatic longint lane(input int k);
        logic [DW-1:0] v;
        v = i_data_bus[k*DW +: DW];
        return longint'(signed'(v));
    endfunction

    task automatic model_accept();
        longint s = 0;
        longint t;
        bit c = 0;
        for (int k = 0; k < N; k++) if (i_valid[k]) s += lane(k);
        if (!i_acc_en) begin
            exp_q.push_back('{s, 1'b0});
        end else begin
            t = m_acc + s;
`ifdef ADDER_TREE_SAT_EN
            if (t > MAXV) begin t = MAXV; c = 1; end
            if (t < MINV) begin t = MINV; c = 1; end
`else
            t = wrapv(t);
`endif
            if (!i_last) begin
                m_acc = t;
                m_sticky |= c;
            end else begin
                exp_q.push_back('{t, m_sticky | c});
                m_acc = 0;
                m_sticky = 0;
            end
        end
    endtask

    // Inputs are set just after a negedge; the following posedge samples them.
    task automatic tick();
        bit exp_ready;
        #1;
        last_acc = 0;
        if (rst) begin
            exp_q.delete();
            m_acc = 0;
            m_sticky = 0;
        end else begin
            exp_ready = !(o_valid && !i_ready);
            check("o_ready", o_ready, exp_ready);
            if (!o_ready) saw_stall = 1;
            obs_valid = o_valid;
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", o_valid, 0);
                end else begin
                    check("data", longint'(signed'(o_data_bus)), exp_q[0].d);
                    check("sat", o_sat, exp_q[0].s);
                    if (i_ready) begin
                        delivered++;
                        last_out = longint'(signed'(o_data_bus));
                        last_sat = o_sat;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("idle_data", o_data_bus, 0);
                check("idle_sat", o_sat, 0);
            end
            if (exp_ready && i_en && (|i_valid)) begin
                model_accept();
                last_acc = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        i_en = 1; i_valid = '0; i_acc_en = 0; i_last = 0; i_ready = 1;
    endtask

    task automatic fill_random();
        i_data_bus = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic set_lane(input int k, input int v);
        i_data_bus[k*DW +: DW] = DW'(v);
    endtask

    task automatic beat(input logic [N-1:0] v, input bit acc, input bit last);
        i_en = 1; i_valid = v; i_acc_en = acc; i_last = last;
        tick();
    endtask

    task automatic wait_out(input string tag, input longint exp);
        int start = delivered;
        int n = 0;
        idle();
        while (delivered == start && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_arrived"}, delivered - start, 1);
        check(tag, last_out, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int start;
        int t;
        int b;
        rst = 1; idle(); i_data_bus = '0;
        @(negedge clk);
        repeat (3) tick();
        rst = 0;
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data_bus, 0);
        check("rst_sat", o_sat, 0);
        check("rst_ready", o_ready, 1);

        // Lanes 1..8 all valid: sum 36 with LEVELS+1 cycle latency.
        for (int k = 0; k < N; k++) set_lane(k, k + 1);
        beat('1, 0, 0);
        lat = 0;
        obs_valid = 0;
        idle();
        while (!obs_valid && lat < 20) begin
            lat++;
            tick();
        end
        check("latency", lat, LV + 1);
        check("sum_1_to_8", last_out, 36);

        fill_random();
        set_lane(0, -5); set_lane(1, 7);
        beat(8'b0000_0011, 0, 0);
        wait_out("mask_sign", 2);

        for (int k = 0; k < N; k++) set_lane(k, -32768);
        beat('1, 0, 0);
        wait_out("all_min", -262144);

        // Accumulation group 10+20+30, masked lanes carry random junk.
        start = delivered;
        fill_random(); set_lane(0, 10); beat(8'h01, 1, 0);
        fill_random(); set_lane(0, 20); beat(8'h01, 1, 0);
        idle();
        repeat (6) tick();
        check("acc_no_early", delivered - start, 0);
        fill_random(); set_lane(0, 30); beat(8'h01, 1, 1);
        wait_out("acc_60", 60);
        fill_random(); set_lane(3, 5); beat(8'h08, 1, 1);
        wait_out("acc_fresh", 5);

        // Backpressure: 6 beats streamed while output stalls for 5 cycles.
        start = delivered;
        saw_stall = 0;
        t = 0; b = 0;
        while (b < 6 && t < 60) begin
            i_ready = !(t >= 5 && t < 10);
            fill_random(); set_lane(0, 100 + b);
            i_en = 1; i_valid = 8'h01; i_acc_en = 0; i_last = 0;
            tick();
            if (last_acc) b++;
            t++;
        end
        idle();
        t = 0;
        while (delivered - start < 6 && t < 40) begin
            tick();
            t++;
        end
        check("bp_stall_seen", saw_stall, 1);
        check("bp_count", delivered - start, 6);
        check("bp_last", last_out, 105);

        // Long positive accumulation drives past the top of the output range.
        for (int k = 0; k < N; k++) set_lane(k, 32767);
        for (int i = 0; i < 260; i++) beat('1, 1, i == 259);
        wait_out("acc_over", exp_q.size() > 0 ? exp_q[exp_q.size()-1].d : 0);
`ifdef ADDER_TREE_SAT_EN
        check("over_value", last_out, MAXV);
        check("over_sat", last_sat, 1);
`else
        check("over_value", last_out, 260 * 262136 - (longint'(1) << OW));
        check("over_sat", last_sat, 0);
`endif

        // Random traffic with bubbles, enable gaps and backpressure.
        for (int i = 0; i < 400; i++) begin
            fill_random();
            i_en     = ($urandom_range(0, 9) != 0);
            i_valid  = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
            i_acc_en = ($urandom_range(0, 9) < 3);
            i_last   = ($urandom_range(0, 9) < 4);
            i_ready  = ($urandom_range(0, 9) < 8);
            tick();
        end
        idle();
        t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            tick();
            t++;
        end
        check("drain_empty", exp_q.size(), 0);

        // Reset mid-stream with a partial group and beats in flight.
        for (int k = 0; k < N; k++) set_lane(k, 50);
        beat(8'h01, 1, 0);
        beat('1, 0, 0);
        rst = 1;
        tick();
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_data", o_data_bus, 0);
        tick();
        rst = 0;
        fill_random(); set_lane(2, 7);
        beat(8'h04, 1, 1);
        wait_out("post_rst_group", 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
